// File: rtl/ctrl_pipeline_chain.sv
// Control-word pipeline chain from ID through the downstream stages.
// Provides per-stage field masking, bubble/stall injection, flush, freeze, valid tracking and perf counters.
module ctrl_pipeline_chain #(
  parameter int                    CW         = 21,
  parameter int                    STAGES     = 3,
  parameter logic [CW*STAGES-1:0]  KEEP_MASKS = {21'h000460, 21'h000C7F, 21'h07FE7F},
  parameter logic [CW-1:0]         NOP_VALUE  = '0,
  parameter int                    CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CW-1:0]          id_ctrl_in,
  input  logic                   nop_insert,
  input  logic                   stall,
  input  logic                   freeze,
  input  logic [STAGES-1:0]      flush,
  input  logic                   clear_count,
  output logic [CW*STAGES-1:0]   stage_ctrl_out,
  output logic [STAGES-1:0]      stage_valid,
  output logic [CNT_W-1:0]       bubble_count,
  output logic [CNT_W-1:0]       retire_count
);

  logic [CW-1:0]     stage_q   [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [CW-1:0]     adv_word  [STAGES];
  logic [STAGES-1:0] adv_valid;
  logic              bubble_in;
  logic              bubble_inc;
  logic              retire_inc;

  function automatic logic [CW-1:0] keep_mask(input int k);
    return KEEP_MASKS[k*CW +: CW];
  endfunction

  assign bubble_in     = nop_insert | stall;
  assign adv_word[0]   = (bubble_in ? NOP_VALUE : id_ctrl_in) & keep_mask(0);
  assign adv_valid[0]  = ~bubble_in;

  // Each later stage takes the pre-edge contents of its predecessor, re-masked.
  generate
    for (genvar k = 1; k < STAGES; k++) begin : g_shift
      assign adv_word[k]  = stage_q[k-1] & keep_mask(k);
      assign adv_valid[k] = valid_q[k-1];
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_out
      assign stage_ctrl_out[k*CW +: CW] = stage_q[k];
    end
  endgenerate

  assign stage_valid = valid_q;
  assign bubble_inc  = bubble_in & ~freeze & ~flush[0];
  assign retire_inc  = valid_q[STAGES-1] & ~freeze & ~flush[STAGES-1];

  // Flush wins over freeze so a frozen pipe can still drop a wrong-path word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= NOP_VALUE & keep_mask(k);
        valid_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush[k]) begin
          stage_q[k] <= NOP_VALUE & keep_mask(k);
          valid_q[k] <= 1'b0;
        end else if (!freeze) begin
          stage_q[k] <= adv_word[k];
          valid_q[k] <= adv_valid[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (clear_count) begin
      bubble_count <= '0;
    end else if (bubble_inc && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count <= '0;
    end else if (clear_count) begin
      retire_count <= '0;
    end else if (retire_inc && (retire_count != '1)) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline_chain.sv
// Directed bench for ctrl_pipeline_chain: a small stage model plus a retire-order scoreboard queue.
module tb_ctrl_pipeline_chain;

  localparam int CW      = 21;
  localparam int ST      = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  localparam logic [CW-1:0] M0 = 21'h07FE7F;
  localparam logic [CW-1:0] M1 = 21'h000C7F;
  localparam logic [CW-1:0] M2 = 21'h000460;

  logic                clk;
  logic                reset;
  logic [CW-1:0]       id_ctrl_in;
  logic                nop_insert;
  logic                stall;
  logic                freeze;
  logic [ST-1:0]       flush;
  logic                clear_count;
  logic [CW*ST-1:0]    stage_ctrl_out;
  logic [ST-1:0]       stage_valid;
  logic [CNT_W-1:0]    bubble_count;
  logic [CNT_W-1:0]    retire_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [CW-1:0] mw [ST];
  logic [ST-1:0] mv;
  int            mb;
  int            mr;
  logic [CW-1:0] sb [$];

  ctrl_pipeline_chain #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_ctrl_in     (id_ctrl_in),
    .nop_insert     (nop_insert),
    .stall          (stall),
    .freeze         (freeze),
    .flush          (flush),
    .clear_count    (clear_count),
    .stage_ctrl_out (stage_ctrl_out),
    .stage_valid    (stage_valid),
    .bubble_count   (bubble_count),
    .retire_count   (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mask_of(input int k);
    case (k)
      0:       return M0;
      1:       return M1;
      default: return M2;
    endcase
  endfunction

  // Queue position of the word held in stage s (oldest word sits at index 0).
  function automatic int idx_of(input int s);
    int n = 0;
    for (int j = s + 1; j < ST; j++) if (mv[j]) n++;
    return n;
  endfunction

  task automatic compareVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] miscompare on %s", tag);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < ST; k++) mw[k] = '0;
    mv = '0;
    mb = 0;
    mr = 0;
    sb.delete();
  endtask

  task automatic checkOutput();
    compareVal("stage_ctrl_out", 64'({mw[2], mw[1], mw[0]}), 64'(stage_ctrl_out));
    compareVal("stage_valid",    64'(mv),                     64'(stage_valid));
    compareVal("bubble_count",   64'(mb),                     64'(bubble_count));
    compareVal("retire_count",   64'(mr),                     64'(retire_count));
  endtask

  task automatic applyStimulus(input logic [CW-1:0] id, input logic nop, input logic st,
                               input logic frz, input logic [ST-1:0] fl, input logic clr);
    logic [CW-1:0] nw [ST];
    logic [ST-1:0] nv;
    logic [CW-1:0] exp_w;
    int            nb;
    int            nr;
    logic          bub;
    id_ctrl_in  = id;
    nop_insert  = nop;
    stall       = st;
    freeze      = frz;
    flush       = fl;
    clear_count = clr;
    bub         = nop | st;
    if (frz) begin
      for (int k = 0; k < ST; k++) if (fl[k] && mv[k]) sb.delete(idx_of(k));
    end else begin
      if (fl[1] && mv[0]) sb.delete(idx_of(0));
      if (fl[2] && mv[1]) sb.delete(idx_of(1));
      if (mv[2]) begin
        if (sb.size() > 0) exp_w = sb.pop_front();
        else               exp_w = 'x;
        if (!fl[2]) compareVal("retire_word", 64'(stage_ctrl_out[2*CW +: CW]), 64'(exp_w));
      end
      if (!fl[0] && !bub) sb.push_back(id & M0 & M1 & M2);
    end
    for (int k = 0; k < ST; k++) begin
      if (fl[k]) begin
        nw[k] = '0;
        nv[k] = 1'b0;
      end else if (frz) begin
        nw[k] = mw[k];
        nv[k] = mv[k];
      end else if (k == 0) begin
        nw[0] = bub ? '0 : (id & M0);
        nv[0] = ~bub;
      end else begin
        nw[k] = mw[k-1] & mask_of(k);
        nv[k] = mv[k-1];
      end
    end
    if (clr)                                          nb = 0;
    else if (!frz && !fl[0] && bub && mb < CNT_MAX)   nb = mb + 1;
    else                                              nb = mb;
    if (clr)                                          nr = 0;
    else if (!frz && mv[2] && !fl[2] && mr < CNT_MAX) nr = mr + 1;
    else                                              nr = mr;
    @(posedge clk);
    #1;
    for (int k = 0; k < ST; k++) mw[k] = nw[k];
    mv = nv;
    mb = nb;
    mr = nr;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; id_ctrl_in = '0; nop_insert = 1'b0; stall = 1'b0;
    freeze = 1'b0; flush = '0; clear_count = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b0;

    // Single word walks through the three stages, then retires.
    applyStimulus(21'h1FFFFF, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    compareVal("t1_stage0", 64'(stage_ctrl_out[0 +: CW]), 64'h07FE7F);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    compareVal("t1_stage1", 64'(stage_ctrl_out[CW +: CW]), 64'h000C7F);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    compareVal("t1_stage2", 64'(stage_ctrl_out[2*CW +: CW]), 64'h000460);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    compareVal("t1_retire", 64'(retire_count), 64'd1);

    // One bubble inside a stream of full words.
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 7; i++)
      applyStimulus(21'h1FFFFF, (i == 3), 1'b0, 1'b0, 3'b000, 1'b0);
    compareVal("t2_bubble", 64'(bubble_count), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    compareVal("t2_retire", 64'(retire_count), 64'd6);

    // Freeze a full pipe for three edges, then resume in order.
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    applyStimulus(21'h1FFFFF, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000420, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000060, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(21'h000001, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    applyStimulus(21'h000440, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000020, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000400, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);

    // Flush the middle stage, plain and under freeze.
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    applyStimulus(21'h1FFFFF, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000420, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000060, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000440, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
    compareVal("t4_stage2_old", 64'(stage_ctrl_out[2*CW +: CW]), 64'h000420);
    applyStimulus(21'h000020, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000400, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
    compareVal("t4_frz_flush_v1", 64'(stage_valid[1]), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);

    // Asynchronous reset between edges with a full pipe.
    applyStimulus(21'h1FFFFF, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000460, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h000040, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    #3 reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    compareVal("t5_async_clear", 64'(stage_ctrl_out), 64'd0);
    #1 reset = 1'b0;
    applyStimulus(21'h000420, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(21'h1FFFFF, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);

    // Bubble counter saturation and clear priority.
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(21'h1FFFFF, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    compareVal("t6_saturate", 64'(bubble_count), 64'd15);
    applyStimulus(21'h1FFFFF, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    compareVal("t6_clear", 64'(bubble_count), 64'd0);
    applyStimulus(21'h1FFFFF, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    compareVal("t6_after_clear", 64'(bubble_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
